// File: rtl/burst_read_controller_pkg.sv
// burst_read_controller_pkg: UART packet bus beat type shared by receiver, transmitter and responders.
package burst_read_controller_pkg;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;
endpackage

// File: rtl/burst_read_controller.sv
// burst_read_controller: decodes read requests and streams register words back MSB-first as one packet.
// Define READ_CTRL_ERROR_RESP_EN to answer malformed requests with a 1-byte 8'hEE packet.
module burst_read_controller
    import burst_read_controller_pkg::*;
#(
    parameter int         DATA_BYTES   = 4,
    parameter int         ADDR_WIDTH   = 8,
    parameter int         MAX_BURST    = 16,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] LOCAL_ADDR   = 8'h00
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  UART_PACKET              ipRxStream,
    input  logic                    ipTxReady,
    input  logic [DATA_BYTES*8-1:0] ipReadData,
    output UART_PACKET              opTxStream,
    output logic [ADDR_WIDTH-1:0]   opReadAddress,
    output logic                    opBusy
);
    localparam int         DW   = DATA_BYTES * 8;
    localparam logic [7:0] DB8  = 8'(DATA_BYTES);
    localparam logic [7:0] MAXB = 8'(MAX_BURST);
    localparam logic [3:0] LAT  = 4'(READ_LATENCY);
    localparam logic [3:0] LAST = 4'(DATA_BYTES - 1);
    localparam logic [3:0] PEN  = 4'(DATA_BYTES - 2);

    typedef enum logic [2:0] {
        IDLE, RX_COUNT, READ_WAIT, SEND
`ifdef READ_CTRL_ERROR_RESP_EN
        , ERROR
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            dst_q, dst_d, len_q, len_d, words_q, words_d;
    logic [3:0]            wait_q, wait_d, byte_q, byte_d;
    logic [DW-1:0]         shift_q, shift_d, sh;
    logic                  first_q, first_d;
    UART_PACKET            tx_q, tx_d;
    logic [7:0]            cnt;
    logic                  rx_take, unused_rx;

    assign rx_take   = ipRxStream.Valid && (ipRxStream.Destination == LOCAL_ADDR);
    assign unused_rx = ^{ipRxStream.Length, ipRxStream.Data};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        len_d   = len_q;
        words_d = words_q;
        wait_d  = wait_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        first_d = first_q;
        tx_d    = tx_q;
        cnt     = (ipRxStream.Data == 8'd0) ? 8'd1 : ipRxStream.Data;
        sh      = shift_q << 8;
        case (state_q)
            IDLE: if (rx_take && ipRxStream.SoP) begin
                addr_d  = ipRxStream.Data[ADDR_WIDTH-1:0];
                dst_d   = ipRxStream.Source;
                words_d = 8'd1;
                len_d   = DB8;
                wait_d  = LAT + 4'd1;
                first_d = 1'b1;
                state_d = ipRxStream.EoP ? READ_WAIT : RX_COUNT;
            end
            RX_COUNT: if (rx_take) begin
                if (ipRxStream.EoP && cnt <= MAXB) begin
                    words_d = cnt;
                    len_d   = cnt * DB8;
                    state_d = READ_WAIT;
                end else begin
`ifdef READ_CTRL_ERROR_RESP_EN
                    state_d = ERROR;
                    tx_d    = '{Source: LOCAL_ADDR, Destination: dst_q, Length: 8'd1, Data: 8'hEE,
                                SoP: 1'b1, EoP: 1'b1, Valid: 1'b1};
`else
                    state_d = IDLE;
`endif
                end
            end
            READ_WAIT: if (wait_q == 4'd0) begin
                shift_d = ipReadData;
                byte_d  = 4'd0;
                state_d = SEND;
                tx_d    = '{Source: LOCAL_ADDR, Destination: dst_q, Length: len_q, Data: ipReadData[DW-1 -: 8],
                            SoP: first_q, EoP: (words_q == 8'd1) && (DATA_BYTES == 1), Valid: 1'b1};
            end else begin
                wait_d = wait_q - 4'd1;
            end
            SEND: if (ipTxReady) begin
                if (byte_q == LAST) begin
                    tx_d.Valid = 1'b0;
                    tx_d.SoP   = 1'b0;
                    tx_d.EoP   = 1'b0;
                    first_d    = 1'b0;
                    if (words_q == 8'd1) begin
                        words_d = 8'd0;
                        state_d = IDLE;
                    end else begin
                        words_d = words_q - 8'd1;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        wait_d  = LAT;
                        state_d = READ_WAIT;
                    end
                end else begin
                    shift_d    = sh;
                    byte_d     = byte_q + 4'd1;
                    tx_d.Data  = sh[DW-1 -: 8];
                    tx_d.SoP   = 1'b0;
                    tx_d.EoP   = (words_q == 8'd1) && (byte_q == PEN);
                end
            end
`ifdef READ_CTRL_ERROR_RESP_EN
            ERROR: if (ipTxReady) begin
                tx_d.Valid = 1'b0;
                state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            words_q <= '0;
            wait_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            first_q <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            words_q <= words_d;
            wait_q  <= wait_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            first_q <= first_d;
            tx_q    <= tx_d;
        end
    end

    assign opTxStream    = tx_q;
    assign opReadAddress = addr_q;
    assign opBusy        = (state_q != IDLE);
endmodule
